// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Digit glyphs 0-9 for a common-anode display.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  // 16-entry pattern table indexed by the 4-bit code; codes 10-15 show a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
    SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef logic [1:0] digit_idx_t;

  // Everything that leaves the block toward the display pins in one bundle.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  dp;
  } pin_drive_t;

  localparam pin_drive_t DRIVE_OFF = '{an: '1, seg: SEG_BLANK, dp: 1'b1};

  // Active-low one-hot anode select for a digit index.
  function automatic logic [NUM_DIGITS-1:0] digit_anode(input digit_idx_t i);
    return ~(4'b0001 << i);
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational 4-bit code to active-low seven-segment decoder with blanking.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank overrides the glyph; otherwise look up the pattern table.
  always_comb begin
    seg = SEG_TABLE[digit];
    if (blank) seg = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Captures the digits and the
// decimal-point mask once per frame, then scans one digit per slot with a
// dark guard interval at the start of each slot to avoid ghosting.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  input  logic        display_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_CNT = PW'(GUARD);

  logic [PW-1:0] pre;
  digit_idx_t    idx;
  logic [15:0]   sh_bcd;
  logic [3:0]    sh_dp;

  logic          slot_end;
  logic          frame_end;
  logic          lit;
  logic [3:0]    lead_zero;
  logic [3:0]    blank_mask;
  logic [3:0]    sel_digit;
  logic          sel_blank;
  logic [6:0]    dec_seg;
  pin_drive_t    drive_next;

  assign slot_end  = (pre == PRE_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  // Slot prescaler: counts through one digit slot and wraps.
  always_ff @(posedge clock) begin
    if (reset)         pre <= '0;
    else if (slot_end) pre <= '0;
    else               pre <= pre + 1'b1;
  end

  // Scan index: moves to the next digit at the end of every slot.
  always_ff @(posedge clock) begin
    if (reset)         idx <= '0;
    else if (slot_end) idx <= idx + 1'b1;
  end

  // Frame shadow: a single capture per frame keeps the display tear-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_bcd <= '0;
      sh_dp  <= '0;
    end else if (frame_end) begin
      sh_bcd <= bcd;
      sh_dp  <= dp_mask;
    end
  end

  // Leading-zero mask: a digit is blank when it and every digit left of it is
  // zero. The rightmost digit always shows so zero reads as "0".
  always_comb begin
    lead_zero[3] = (sh_bcd[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (sh_bcd[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (sh_bcd[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    blank_mask   = blank_lead ? lead_zero : 4'b0000;
  end

  assign sel_digit = sh_bcd[{idx, 2'b00} +: 4];
  assign sel_blank = blank_mask[idx];

  bcd_to_seg7 u_dec (
    .digit (sel_digit),
    .blank (sel_blank),
    .seg   (dec_seg)
  );

  // Drive for the next cycle: dark during the guard window or when disabled.
  always_comb begin
    lit        = display_en && (pre >= GUARD_CNT);
    drive_next = DRIVE_OFF;
    if (lit) begin
      drive_next.an  = digit_anode(idx);
      drive_next.seg = dec_seg;
      drive_next.dp  = ~sh_dp[idx];
    end
  end

  // Registered pin drive and frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      an         <= DRIVE_OFF.an;
      seg        <= DRIVE_OFF.seg;
      dp         <= DRIVE_OFF.dp;
      frame_tick <= 1'b0;
    end else begin
      an         <= drive_next.an;
      seg        <= drive_next.seg;
      dp         <= drive_next.dp;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with REFRESH_DIV=8, GUARD=2 (32-cycle frame).
module tb_seg7_scan_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] bcd;
  logic [3:0]  dp_mask;
  logic        blank_lead;
  logic        display_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seg7_scan_driver #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .bcd        (bcd),
    .dp_mask    (dp_mask),
    .blank_lead (blank_lead),
    .display_en (display_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } obs_t;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dpm;
    logic            bl;
    logic [3:0][6:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]      dpo;    // expected active-low dp per digit
  } vec_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[9];

  function automatic obs_t observe();
    obs_t o;
    o.an  = an;
    o.seg = seg;
    o.dp  = dp;
    o.ft  = frame_tick;
    return o;
  endfunction

  task automatic check(input string tag, input int j, input obs_t act, input obs_t e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s cyc%0d: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
               tag, j, act.an, act.seg, act.dp, act.ft, e.an, e.seg, e.dp, e.ft);
    end
  endtask

  // Wait for the next frame_tick (the current cycle is never taken).
  task automatic wait_tick(input string tag);
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!frame_tick && k < 100);
    n_cmp++;
    if (!frame_tick) begin
      n_err++;
      $display("FAIL %s: frame_tick not seen, got 0 want 1 within 100 cycles", tag);
    end
  endtask

  // Frame cycle j (0 = first cycle after a frame_tick / reset release) shows
  // slot j/8 at prescaler phase j%8. Optional display_en drop: driven low after
  // the compare of cycle off_from, back high after cycle off_from+off_len.
  task automatic run_frame(input logic [3:0][6:0] es, input logic [3:0] edp, input int n,
                           input int off_from, input int off_len, input string tag);
    obs_t e;
    obs_t got;
    int   s;
    int   p;
    bit   on;
    logic [3:0] oh;
    for (int j = 0; j < n; j++) begin
      s  = j / 8;
      p  = j % 8;
      on = (p >= 2) && !(off_from >= 0 && j > off_from && j <= off_from + off_len);
      oh = 4'b0001 << s;
      e.an  = on ? ~oh : 4'hF;
      e.seg = on ? es[s] : 7'h7F;
      e.dp  = on ? edp[s] : 1'b1;
      e.ft  = (j == 31);
      exp_q.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge clock);
      got = observe();
      check(tag, j, got, exp_q.pop_front());
      if (off_from >= 0) begin
        if (j == off_from) display_en = 1'b0;
        if (j == off_from + off_len) display_en = 1'b1;
      end
    end
  endtask

  localparam logic [3:0][6:0] ZEROS = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [3:0][6:0] S1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [3:0][6:0] S4321 = {7'h19, 7'h30, 7'h24, 7'h79};
  localparam obs_t RST_OBS = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};

  initial begin
    tbl[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
    tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    tbl[3] = '{16'h00AF, 4'b0100, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h3F}, 4'b1011};
    tbl[4] = '{16'h0A00, 4'b1001, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40}, 4'b0110};
    tbl[5] = '{16'h9876, 4'b1111, 1'b1, {7'h10, 7'h00, 7'h78, 7'h02}, 4'b0000};
    tbl[6] = '{16'h5000, 4'b0000, 1'b1, {7'h12, 7'h40, 7'h40, 7'h40}, 4'b1111};
    tbl[7] = '{16'h0001, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h79}, 4'b1111};
    tbl[8] = '{16'hC0DE, 4'b0010, 1'b1, {7'h3F, 7'h40, 7'h3F, 7'h3F}, 4'b1101};

    reset      = 1'b1;
    bcd        = 16'h1234;
    dp_mask    = 4'b0000;
    blank_lead = 1'b0;
    display_en = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_state", 0, observe(), RST_OBS);
    reset = 1'b0;

    // First frame after reset shows the cleared shadow.
    run_frame(ZEROS, 4'hF, 32, -1, 0, "first_frame");

    foreach (tbl[i]) begin
      bcd        = tbl[i].bcd;
      dp_mask    = tbl[i].dpm;
      blank_lead = tbl[i].bl;
      wait_tick($sformatf("vec%0d_tick", i));
      run_frame(tbl[i].segs, tbl[i].dpo, 32, -1, 0, $sformatf("vec%0d", i));
    end

    // Inputs churning every cycle must not reach the display mid-frame.
    bcd        = 16'h1234;
    dp_mask    = 4'b0000;
    blank_lead = 1'b0;
    wait_tick("churn_tick");
    fork
      run_frame(S1234, 4'hF, 32, -1, 0, "churn_hold");
      begin
        repeat (28) begin
          @(negedge clock);
          bcd = 16'($urandom);
        end
        bcd = 16'h4321;
      end
    join
    wait_tick("churn_tick2");
    run_frame(S4321, 4'hF, 32, -1, 0, "churn_after");

    // display_en low for 20 cycles mid-frame; scan phase must be undisturbed.
    bcd = 16'h1234;
    wait_tick("en_tick");
    run_frame(S1234, 4'hF, 32, 9, 20, "en_gap");
    run_frame(S1234, 4'hF, 32, -1, 0, "en_after");

    // Reset landing at pre=5, idx=2 restarts the scan from the cleared state.
    wait_tick("rst_tick");
    run_frame(S1234, 4'hF, 21, -1, 0, "pre_rst");
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset", 0, observe(), RST_OBS);
    reset = 1'b0;
    run_frame(ZEROS, 4'hF, 32, -1, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
